// File: rtl/mux_rr_scheduler.sv
// mux_rr_scheduler: round-robin grant of one output lane among N_REQ requesters with min hold, fairness cap and turnaround gap
module mux_rr_scheduler #(
  parameter int N_REQ = 4,
  parameter int W_DATA = 2,
  parameter int HOLD_CYCLES = 4,
  parameter int MAX_GRANT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ-1:0]          req,
  input  logic [N_REQ*W_DATA-1:0]   data,
  output logic [N_REQ-1:0]          gnt,
  output logic [$clog2(N_REQ)-1:0]  sel,
  output logic                      valid,
  output logic [W_DATA-1:0]         out_data
);
  localparam int SW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_GRANT + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state;
  logic [SW-1:0] ptr, idx;
  logic [CW-1:0] cnt;
  logic rel;
  // Descending scan so the requester closest to ptr is written last and wins
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N_REQ]) idx = SW'((int'(ptr) + i) % N_REQ);
  end
  assign rel = (cnt >= CW'(HOLD_CYCLES) && !req[sel]) ||
               (cnt == CW'(MAX_GRANT) && |(req & ~gnt));
  assign out_data = valid ? data[int'(sel)*W_DATA +: W_DATA] : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      valid <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (|req) begin
        state <= GRANT;
        gnt   <= N_REQ'(1) << idx;
        sel   <= idx;
        valid <= 1'b1;
        cnt   <= CW'(1);
      end
    end else if (rel) begin
      state <= IDLE;
      gnt   <= '0;
      valid <= 1'b0;
      cnt   <= '0;
      ptr   <= (sel == SW'(N_REQ - 1)) ? '0 : sel + 1'b1;
    end else begin
      cnt <= (cnt == CW'(MAX_GRANT)) ? cnt : cnt + 1'b1;
    end
  end
endmodule
